uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the next generation of the team's fixed 8N1 transmitter. It buffers words in a small FIFO. Data width, parity and stop-bit count are configurable, and the block can send a line break. It sits between the CPLD command/bridge logic and the uart_tx pin and emits one line bit per baud_clk cycle. Consecutive buffered frames go out back-to-back with no idle gap.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, words buffered; power of two, minimum 2.
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level (derived; do not override).

Ports:
baud_clk  in  1  bit clock; one line bit per cycle; all state on posedge.
rst_n  in  1  reset, asynchronous, active-low.
tx_start  in  1  push strobe; tx_data is written to the FIFO on any posedge with tx_start=1.
tx_data  in  DATA_W  word to transmit, LSB sent first.
parity_en  in  1  1 = parity bit appended after the data bits.
parity_odd  in  1  1 = odd parity, 0 = even parity; ignored when parity_en=0.
stop2  in  1  1 = two stop bits, 0 = one stop bit.
break_req  in  1  request a line break (uart_tx held low).
err_clr  in  1  synchronous clear of error.
uart_tx  out  1  serial line; idle = 1.
tx_busy  out  1  1 while a frame or break is on the line.
tx_done  out  1  one-cycle pulse during the final stop-bit cycle of each frame.
tx_full  out  1  FIFO full.
fifo_level  out  LVL_W  number of words in the FIFO.
error  out  1  sticky overflow flag.

Behaviour:
- Reset (async, rst_n=0): uart_tx=1, tx_busy=0, tx_done=0, tx_full=0, fifo_level=0, error=0, FIFO emptied, FSM=IDLE. Reset mid-frame aborts the frame immediately.
- All outputs are registered.
- FSM states and per-state line value:
  - IDLE: 1.
  - START: 0.
  - DATA: tx bits, LSB first, DATA_W cycles, bit counter 0..DATA_W-1.
  - PARITY: 1 cycle.
  - STOP1: 1.
  - STOP2: 1.
  - BREAK: 0.
  - BRK_MARK: 1, one cycle.
- Frame start (IDLE, or STOP1/STOP2 when that is the last stop bit):
  - break_req=1 goes to BREAK; break has priority over the FIFO.
  - Otherwise, a non-empty FIFO pops one word into the shift register, latches parity_en/parity_odd/stop2, and goes to START.
  - Otherwise go to IDLE.
- Config inputs are sampled only at frame start; changes mid-frame have no effect on that frame.
- Transitions:
  - DATA: after DATA_W cycles, go to PARITY if parity_en, else STOP1.
  - PARITY: go to STOP1.
  - STOP1: go to STOP2 if stop2, else frame-start logic.
  - STOP2: go to frame-start logic.
- Parity bit = XOR of the data bits, XOR parity_odd.
- Frame length = 1 + DATA_W + parity_en + (1 + stop2) cycles.
- Latency: with the FSM idle and the FIFO empty, a tx_start at edge N gives uart_tx=0 (start bit) after edge N+1.
- Back-to-back: the next start bit follows the last stop bit directly.
- Break: uart_tx=0 for as long as break_req stays 1 (minimum 1 cycle). When break_req drops, output one BRK_MARK cycle (1), then run frame-start logic. break_req asserted mid-frame waits for the frame boundary. tx_done does not pulse for a break.
- tx_busy = 1 in every state except IDLE.
- FIFO:
  - Push and pop on the same edge are both performed; the level is unchanged.
  - Push while full and not popping: the word is dropped, error is set to 1, and the level stays at FIFO_DEPTH.
  - Push while full and popping on the same edge: the push is accepted with no error.
  - Pointers wrap modulo FIFO_DEPTH.
- error: cleared by err_clr. If a set event and err_clr occur on the same edge, set wins.

Decomposition:
- Package uart_pkg holds: the FSM state enum (IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK, BRK_MARK), line level constants MARK=1/SPACE=0, and a parity-calc function.
- Sub-module uart_tx_fifo (parameters DATA_W, FIFO_DEPTH; ports push, pop, din, dout, full, empty, level), one register-array FIFO.
- The top level holds the FSM, shift register, bit counter and error logic.

Test Plan:
1. DATA_W=8, 8N1, push 0xA5 on an idle line -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles starting one cycle after the push; tx_done pulses in cycle 10.
2. 0xA5 with even parity and stop2=1 -> 12-cycle frame, parity bit 0, two stop bits of 1. The same word with odd parity -> parity bit 1.
3. Push 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 10-cycle frames with no idle cycle between them; fifo_level peaks at 2, tx_done pulses 3 times.
4. FIFO_DEPTH=4 with the line busy: push 6 words in 6 cycles -> tx_full=1, error=1, exactly the first 5 words transmitted (one popped before full), 6th dropped; err_clr -> error=0.
5. break_req=1 for 5 cycles during a frame -> the frame completes, then uart_tx=0 for the remaining held cycles (at least 1), then one mark cycle, then the pending FIFO word is sent.
6. rst_n pulsed low mid-DATA -> uart_tx=1 and fifo_level=0 immediately; the next push transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BREAK,
        BRK_MARK
    } tx_state_t;

    localparam logic MARK  = 1'b1;
    localparam logic SPACE = 1'b0;

    localparam int unsigned MAX_DATA_W = 9;

    // Per-frame line configuration captured when a frame starts.
    typedef struct packed {
        logic par_en;
        logic par_odd;
        logic stop2;
    } frame_cfg_t;

    // Even parity over the data word, inverted for odd parity.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Register-array FIFO buffering words ahead of the transmit shifter.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            baud_clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DATA_W-1:0]               din,
    output logic [DATA_W-1:0]               dout,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_full;
    logic              w_do_pop;
    logic              w_do_push;
    logic [LVL_W-1:0]  w_level_nxt;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign w_do_pop  = pop && (r_level != '0);
    assign w_do_push = push && (!r_full || w_do_pop);

    always_comb begin
        w_level_nxt = r_level;
        case ({w_do_push, w_do_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge baud_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: configurable data width, parity, stop bits and
// line break; frames go out back-to-back, one line bit per baud_clk cycle.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              baud_clk,
    input  logic              rst_n,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    input  logic              break_req,
    input  logic              err_clr,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_full,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              error
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    frame_cfg_t        r_cfg;
    frame_cfg_t        w_cfg_nxt;
    logic              r_par_bit;
    logic              w_par_nxt;
    logic              w_frame_start;
    logic              w_pop;
    logic              w_line_nxt;
    logic              w_done_nxt;
    logic              w_overflow;

    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic [DATA_W-1:0] w_fifo_dout;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [LVL_W-1:0]  w_fifo_level;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .baud_clk (baud_clk),
        .rst_n    (rst_n),
        .push     (tx_start),
        .pop      (w_pop),
        .din      (tx_data),
        .dout     (w_fifo_dout),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty),
        .level    (w_fifo_level)
    );

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, datapath updates and the line value of the state being entered.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_bit_cnt;
        w_cfg_nxt     = r_cfg;
        w_par_nxt     = r_par_bit;
        w_frame_start = 1'b0;
        w_pop         = 1'b0;
        w_line_nxt    = MARK;
        w_done_nxt    = 1'b0;

        case (r_state)
            IDLE:     w_frame_start = 1'b1;
            START: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
            end
            DATA: begin
                if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                    w_state_nxt = r_cfg.par_en ? PARITY : STOP1;
                end else begin
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
                end
            end
            PARITY:   w_state_nxt = STOP1;
            STOP1: begin
                if (r_cfg.stop2) w_state_nxt   = STOP2;
                else             w_frame_start = 1'b1;
            end
            STOP2:    w_frame_start = 1'b1;
            BREAK:    if (!break_req) w_state_nxt = BRK_MARK;
            BRK_MARK: w_frame_start = 1'b1;
            default:  w_state_nxt = IDLE;
        endcase

        // Frame boundary: a break request outranks buffered data.
        if (w_frame_start) begin
            if (break_req) begin
                w_state_nxt = BREAK;
            end else if (!w_fifo_empty) begin
                w_pop       = 1'b1;
                w_shift_nxt = w_fifo_dout;
                w_cfg_nxt   = '{par_en: parity_en, par_odd: parity_odd, stop2: stop2};
                w_par_nxt   = calc_parity(MAX_DATA_W'(w_fifo_dout), parity_odd);
                w_state_nxt = START;
            end else begin
                w_state_nxt = IDLE;
            end
        end

        case (w_state_nxt)
            START, BREAK: w_line_nxt = SPACE;
            DATA:         w_line_nxt = w_shift_nxt[0];
            PARITY:       w_line_nxt = w_par_nxt;
            default:      w_line_nxt = MARK;
        endcase

        w_done_nxt = (w_state_nxt == STOP2) ||
                     ((w_state_nxt == STOP1) && !w_cfg_nxt.stop2);
    end

    assign w_overflow = tx_start && w_fifo_full && !w_pop;

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_cfg     <= '0;
            r_par_bit <= 1'b0;
            r_tx      <= MARK;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_cfg     <= w_cfg_nxt;
            r_par_bit <= w_par_nxt;
            r_tx      <= w_line_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
            // A new overflow wins over a simultaneous clear.
            r_error   <= w_overflow | (r_error & ~err_clr);
        end
    end

    assign uart_tx    = r_tx;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign tx_full    = w_fifo_full;
    assign fifo_level = w_fifo_level;
    assign error      = r_error;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench: expected line stream built as a queue of frame bits.
module tb_uart_tx_frame;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              baud_clk = 1'b0;
    logic              rst_n    = 1'b1;
    logic              tx_start = 1'b0;
    logic [DATA_W-1:0] tx_data  = '0;
    logic              parity_en  = 1'b0;
    logic              parity_odd = 1'b0;
    logic              stop2      = 1'b0;
    logic              break_req  = 1'b0;
    logic              err_clr    = 1'b0;
    logic              uart_tx;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_full;
    logic [LVL_W-1:0]  fifo_level;
    logic              error;

    uart_tx_frame #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .baud_clk   (baud_clk),
        .rst_n      (rst_n),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .break_req  (break_req),
        .err_clr    (err_clr),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_full    (tx_full),
        .fifo_level (fifo_level),
        .error      (error)
    );

    always #5 baud_clk = ~baud_clk;

    // One expected line cycle: value, busy, done pulse, start-of-frame, boundary follows.
    typedef struct packed {
        bit val;
        bit busy;
        bit done;
        bit sof;
        bit fin;
    } ebit_t;

    ebit_t exp_q[$];
    bit    prev_fin  = 1'b1;
    bit    in_break  = 1'b0;
    bit    m_err     = 1'b0;
    int    total     = 0;
    int    bad       = 0;
    int    done_seen = 0;
    int    lvl_peak  = 0;

    function automatic ebit_t mk(input bit v, input bit b, input bit d, input bit s, input bit f);
        ebit_t e;
        e.val = v; e.busy = b; e.done = d; e.sof = s; e.fin = f;
        return e;
    endfunction

    function automatic int sof_count();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].sof) n++;
        return n;
    endfunction

    function automatic int first_sof();
        foreach (exp_q[i]) if (exp_q[i].sof) return i;
        return -1;
    endfunction

    // Whole frame from the line rules, using the config currently being driven.
    function automatic void append(input logic [DATA_W-1:0] w);
        int ones = 0;
        if (exp_q.size() == 0 && !in_break) exp_q.push_back(mk(1, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 1, 0, 1, 0));
        for (int i = 0; i < int'(DATA_W); i++) begin
            exp_q.push_back(mk(w[i], 1, 0, 0, 0));
            ones += int'(w[i]);
        end
        if (parity_en) exp_q.push_back(mk(((ones % 2) != 0) ^ parity_odd, 1, 0, 0, 0));
        if (stop2) exp_q.push_back(mk(1, 1, 0, 0, 0));
        exp_q.push_back(mk(1, 1, 1, 0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, then drive inputs for the next rising edge.
    task automatic tick(input bit push, input logic [DATA_W-1:0] w, input bit brk, input bit clr);
        ebit_t e;
        int    occ;
        bit    pop_now;
        @(negedge baud_clk);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = mk(1, 0, 0, 0, 1);
        chk("uart_tx",    32'(uart_tx),    32'(e.val));
        chk("tx_busy",    32'(tx_busy),    32'(e.busy));
        chk("tx_done",    32'(tx_done),    32'(e.done));
        chk("fifo_level", 32'(fifo_level), 32'(sof_count()));
        chk("tx_full",    32'(tx_full),    32'(sof_count() == int'(FIFO_DEPTH)));
        chk("error",      32'(error),      32'(m_err));
        if (tx_done === 1'b1) done_seen++;
        if (int'(fifo_level) > lvl_peak) lvl_peak = int'(fifo_level);
        prev_fin = e.fin;
        if (in_break) begin
            if (brk) exp_q.push_front(mk(0, 1, 0, 0, 0));
            else begin
                exp_q.push_front(mk(1, 1, 0, 0, 1));
                in_break = 1'b0;
            end
        end else if (prev_fin && brk) begin
            if (exp_q.size() != 0 && !exp_q[0].busy) void'(exp_q.pop_front());
            exp_q.push_front(mk(0, 1, 0, 0, 0));
            in_break = 1'b1;
        end
        if (clr) m_err = 1'b0;
        if (push) begin
            pop_now = (exp_q.size() != 0) && exp_q[0].sof;
            occ     = sof_count();
            if (occ < int'(FIFO_DEPTH) || pop_now) append(w);
            else m_err = 1'b1;
        end
        tx_start  = push;
        tx_data   = w;
        break_req = brk;
        err_clr   = clr;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(0, '0, 0, 0);
        chk("drain_done", 32'(exp_q.size()), 32'(0));
        idle_n(2);
    endtask

    task automatic check_reset();
        chk("rst_uart_tx", 32'(uart_tx),    32'(1));
        chk("rst_busy",    32'(tx_busy),    32'(0));
        chk("rst_done",    32'(tx_done),    32'(0));
        chk("rst_full",    32'(tx_full),    32'(0));
        chk("rst_level",   32'(fifo_level), 32'(0));
        chk("rst_error",   32'(error),      32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_start = 1'b0; break_req = 1'b0; err_clr = 1'b0;
        #1;
        check_reset();
        exp_q.delete();
        in_break = 1'b0; m_err = 1'b0; prev_fin = 1'b1;
        @(negedge baud_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset();
        @(negedge baud_clk);
        rst_n = 1'b1;

        // 8N1 frame of 0xA5 on an idle line.
        tick(1, 8'hA5, 0, 0);
        drain();

        // Even then odd parity with two stop bits.
        parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
        tick(1, 8'hA5, 0, 0);
        drain();
        parity_odd = 1'b1;
        tick(1, 8'hA5, 0, 0);
        // Config changes mid-frame must not disturb the frame in flight.
        idle_n(4);
        parity_en = 1'b0; stop2 = 1'b0; parity_odd = 1'b0;
        drain();

        // Three pushes on consecutive cycles go out back-to-back.
        done_seen = 0; lvl_peak = 0;
        tick(1, 8'h01, 0, 0);
        tick(1, 8'h02, 0, 0);
        tick(1, 8'h03, 0, 0);
        drain();
        chk("b2b_done_count", 32'(done_seen), 32'(3));
        chk("b2b_level_peak", 32'(lvl_peak),  32'(2));

        // Overflow: six pushes, the sixth dropped; set wins over clear; then clear.
        for (int i = 0; i < 6; i++) tick(1, DATA_W'($urandom), 0, 0);
        tick(1, DATA_W'($urandom), 0, 1);
        tick(0, '0, 0, 1);
        for (int i = 0; i < 40 && !(exp_q.size() != 0 && exp_q[0].sof); i++) tick(0, '0, 0, 0);
        chk("wait_pop_slot", 32'(exp_q.size() != 0 && exp_q[0].sof), 32'(1));
        tick(1, DATA_W'($urandom), 0, 0);
        drain();

        // Break requested mid-frame with a word pending.
        tick(1, DATA_W'($urandom), 0, 0);
        tick(1, DATA_W'($urandom), 0, 0);
        for (int i = 0; i < 40 && !(sof_count() == 1 && first_sof() == 2); i++) tick(0, '0, 0, 0);
        chk("wait_brk_point", 32'(sof_count() == 1 && first_sof() == 2), 32'(1));
        for (int i = 0; i < 5; i++) tick(0, '0, 1, 0);
        drain();
        // Break on an idle line.
        for (int i = 0; i < 3; i++) tick(0, '0, 1, 0);
        drain();

        // Reset in the middle of the data bits with a word still buffered.
        tick(1, DATA_W'($urandom), 0, 0);
        tick(1, DATA_W'($urandom), 0, 0);
        idle_n(5);
        do_reset();
        tick(1, DATA_W'($urandom), 0, 0);
        drain();

        // Random pushes, clears and config changes between buffered words.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 9 && sof_count() == 0 && !in_break) begin
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
                stop2      = 1'($urandom);
            end
            tick(r < 4, DATA_W'($urandom), 0, r == 8);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
